// File: rtl/count_change_fifo_pkg.sv
// Shared defaults and sizing helpers for the count-change FIFO.
package count_change_fifo_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_DEPTH   = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  localparam int DEFAULT_LEVEL_W = $clog2(DEFAULT_DEPTH) + 1;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/count_fifo_mem.sv
// Storage, pointers and occupancy for the count-change FIFO.
// The head entry is kept in its own register so out_data never passes
// through the read mux combinationally.
module count_fifo_mem
  import count_change_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          ready,
  output logic [WIDTH-1:0]              rdata,
  output logic                          valid,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [LW-1:0]    level_next;
  logic [WIDTH-1:0] head_next;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             load_head;

  // Push/pop decisions and the value that becomes the head after this edge.
  always_comb begin
    full       = (level == LW'(DEPTH));
    pop        = valid & ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    do_push    = push & (~full | pop);
    dropped    = push & full & ~pop;
    rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
    level_next = level + LW'(do_push) - LW'(pop);
    load_head  = pop | (do_push & ~valid);
    // The slot becoming head may be the one written this same cycle.
    head_next  = (do_push && (wr_ptr == rd_next)) ? wdata : mem[rd_next];
  end

  // Storage array write port.
  // NOTE: the array is not reset; a slot is only read after it is written,
  // and leaving it out of reset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and registered head of queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      level  <= level_next;
      valid  <= (level_next != '0);
      if (load_head) rdata <= head_next;
    end
  end

endmodule

// File: rtl/count_change_fifo.sv
// Captures a counter value whenever it changes and queues it for a consumer.
// A sticky overflow flag records any change lost because the queue was full.
module count_change_fifo
  import count_change_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              count_in,
  input  logic                          capture_en,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  logic [WIDTH-1:0] prev;
  logic             first;
  logic             push_req;
  logic             dropped;

  // A sample is queued when it is the first since reset or differs from the last one.
  always_comb begin
    push_req = capture_en & (first | (count_in != prev));
  end

  // Change detector history; tracks every sample, accepted by the FIFO or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= '0;
      first <= 1'b1;
    end else if (capture_en) begin
      prev  <= count_in;
      first <= 1'b0;
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (dropped) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  count_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wdata   (count_in),
    .ready   (out_ready),
    .rdata   (out_data),
    .valid   (out_valid),
    .level   (level),
    .dropped (dropped)
  );

endmodule

// File: tb/tb_count_change_fifo.sv
// Self-checking bench for count_change_fifo (WIDTH=4, DEPTH=4).
module tb_count_change_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] count_in;
  logic             capture_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       level;
  logic             overflow;
  logic             clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored values plus change-detector state.
  int q[$];
  int m_prev;
  bit m_first;
  bit m_ovf;

  typedef struct {
    bit ce;
    int cin;
    bit rdy;
    bit clr;
    bit exp_valid;
    int exp_data;
    int exp_level;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[$];

  count_change_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .capture_en (capture_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev  = 0;
    m_first = 1'b1;
    m_ovf   = 1'b0;
  endtask

  // One clock of the behavioural rules, using the inputs present at the edge.
  task automatic model_edge(input bit ce, input int cin, input bit rdy, input bit clr);
    bit pop;
    bit want;
    bit drop;
    pop  = (q.size() > 0) && rdy;
    want = ce && (m_first || cin != m_prev);
    drop = want && (q.size() == DEPTH) && !pop;
    if (ce) begin
      m_prev  = cin;
      m_first = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (want && !drop) q.push_back(cin);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, int'(out_valid), int'(q.size() > 0));
    check({tag, ".level"}, int'(level), q.size());
    check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    if (q.size() > 0) check({tag, ".data"}, int'(out_data), q[0]);
  endtask

  // Drive one cycle of inputs, clock, then compare against the model.
  task automatic step(input bit ce, input int cin, input bit rdy, input bit clr,
                      input string tag);
    capture_en = ce;
    count_in   = WIDTH'(cin);
    out_ready  = rdy;
    clr_ovf    = clr;
    @(posedge clk);
    model_edge(ce, cin, rdy, clr);
    #1;
    compare_model(tag);
  endtask

  initial begin
    rst        = 1'b0;
    capture_en = 1'b0;
    count_in   = '0;
    out_ready  = 1'b0;
    clr_ovf    = 1'b0;
    model_reset();

    // Reset values hold before any clock edge.
    #2;
    check("rst.level", int'(level), 0);
    check("rst.valid", int'(out_valid), 0);
    check("rst.data", int'(out_data), 0);
    check("rst.overflow", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Hold 5 for three captures, then the 1,2,2,3 change sequence.
    vecs.push_back('{1'b1, 5, 1'b0, 1'b0, 1'b1, 5, 1, 1'b0});
    vecs.push_back('{1'b1, 5, 1'b0, 1'b0, 1'b1, 5, 1, 1'b0});
    vecs.push_back('{1'b1, 5, 1'b0, 1'b0, 1'b1, 5, 1, 1'b0});
    vecs.push_back('{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{1'b1, 1, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0});
    vecs.push_back('{1'b1, 2, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0});
    vecs.push_back('{1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{1'b1, 3, 1'b1, 1'b0, 1'b1, 3, 1, 1'b0});
    vecs.push_back('{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    // Pop with out_ready while empty has no effect.
    vecs.push_back('{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ce, vecs[i].cin, vecs[i].rdy, vecs[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tvalid", i), int'(out_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d.tlevel", i), int'(level), vecs[i].exp_level);
      check($sformatf("vec%0d.tovf", i), int'(overflow), int'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d.tdata", i), int'(out_data), vecs[i].exp_data);
    end

    // Six distinct values into a 4-deep FIFO with no consumer.
    for (int v = 0; v < 6; v++) begin
      step(1'b1, v, 1'b0, 1'b0, "fill6");
      if (v == 4) begin
        check("fill6.level_at5", int'(level), 4);
        check("fill6.ovf_at5", int'(overflow), 1);
      end
    end
    for (int v = 0; v < 4; v++) begin
      check("fill6.order", int'(out_data), v);
      step(1'b0, 0, 1'b1, 1'b0, "drain6");
    end
    check("drain6.empty", int'(out_valid), 0);

    // Full FIFO with a simultaneous push and pop.
    step(1'b0, 0, 1'b0, 1'b1, "clr");
    check("clr.ovf", int'(overflow), 0);
    for (int v = 10; v < 14; v++) step(1'b1, v, 1'b0, 1'b0, "fill4");
    step(1'b1, 14, 1'b1, 1'b0, "fullpp");
    check("fullpp.level", int'(level), 4);
    check("fullpp.ovf", int'(overflow), 0);
    for (int v = 11; v < 15; v++) begin
      check("fullpp.order", int'(out_data), v);
      step(1'b0, 0, 1'b1, 1'b0, "drainpp");
    end

    // Clear colliding with a fresh drop keeps overflow set.
    for (int v = 1; v < 5; v++) step(1'b1, v, 1'b0, 1'b0, "fillc");
    step(1'b1, 5, 1'b0, 1'b0, "drop");
    check("drop.ovf", int'(overflow), 1);
    step(1'b1, 6, 1'b0, 1'b1, "dropclr");
    check("dropclr.ovf", int'(overflow), 1);
    step(1'b0, 0, 1'b0, 1'b1, "clronly");
    check("clronly.ovf", int'(overflow), 0);
    check("clronly.data", int'(out_data), 1);

    // Asynchronous reset with three entries stored.
    step(1'b0, 0, 1'b1, 1'b0, "pop1");
    check("pop1.level", int'(level), 3);
    rst = 1'b0;
    #1;
    model_reset();
    check("arst.level", int'(level), 0);
    check("arst.valid", int'(out_valid), 0);
    check("arst.data", int'(out_data), 0);
    check("arst.overflow", int'(overflow), 0);
    #2 rst = 1'b1;
    step(1'b1, 6, 1'b0, 1'b0, "post_rst");
    check("post_rst.level", int'(level), 1);
    check("post_rst.data", int'(out_data), 6);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 5)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_change_fifo.md
COUNT_CHANGE_FIFO -- requirements
Module: count_change_fifo

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the width of the captured count value.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of FIFO entries; legal values are powers of two, 2 or more.
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port count_in  input  WIDTH  SHALL carry the upstream load-counter output value.
REQ-006 Port capture_en  input  1  SHALL qualify count_in as valid for sampling in the current cycle.
REQ-007 Port out_data  output  WIDTH  SHALL present the oldest stored count value.
REQ-008 Port out_valid  output  1  SHALL indicate that out_data holds a stored entry.
REQ-009 Port out_ready  input  1  SHALL indicate that the consumer accepts out_data this cycle.
REQ-010 Port level  output  clog2(DEPTH)+1  SHALL report the current number of stored entries, from 0 to DEPTH.
REQ-011 Port overflow  output  1  SHALL be a sticky flag indicating that at least one change was dropped.
REQ-012 Port clr_ovf  input  1  SHALL clear overflow synchronously.

Function
REQ-013 A register prev SHALL hold the last sampled count, and a flag first SHALL mark that no sample has been taken since reset.
REQ-014 A push request SHALL be raised in a cycle where capture_en=1 and either first=1 or count_in differs from prev.
REQ-015 When capture_en=1, prev SHALL load count_in and first SHALL clear, whether or not the push is accepted.
REQ-016 When capture_en=0, prev, first and the FIFO write side SHALL hold.
REQ-017 A pop SHALL occur in a cycle where out_valid=1 and out_ready=1.
REQ-018 An entry pushed in cycle N into an empty FIFO SHALL appear on out_data with out_valid=1 in cycle N+1; there is no combinational fall-through.
REQ-019 When out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-020 The read and write pointers SHALL wrap modulo DEPTH, and entries SHALL leave in the order they were pushed.
REQ-021 Push without pop: level SHALL increase by 1; pop without push: level SHALL decrease by 1; push and pop together: level SHALL be unchanged.
REQ-022 A push when full with a pop in the same cycle SHALL be accepted.
REQ-023 A push when full without a pop SHALL be dropped, the stored data SHALL be unchanged, and overflow SHALL be 1 from the next cycle.
REQ-024 overflow SHALL remain 1 until a cycle with clr_ovf=1; if clr_ovf coincides with a new drop, overflow SHALL stay 1.
REQ-025 A pop or out_ready when empty SHALL have no effect, and level SHALL not underflow.
REQ-026 All outputs SHALL be driven from registers.

Reset
REQ-027 While rst=0, the following SHALL hold immediately, without waiting for clk: level=0, out_valid=0, out_data=0, overflow=0, pointers=0, prev=0, first=1.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries.
REQ-029 After rst returns to 1, the first capture_en=1 cycle SHALL push unconditionally.

Structure
REQ-030 A shared package SHALL hold the WIDTH and DEPTH defaults and a level-width helper constant.
REQ-031 A single sub-module, count_fifo_mem, SHALL hold the DEPTH-by-WIDTH storage array, pointers, level and the full/empty logic.
REQ-032 The top level SHALL contain the change detector (prev, first) and the overflow flag.

Verification
REQ-033 Reset release, then capture_en=1 with count_in=5 held for 3 cycles, out_ready=0 -> exactly one entry, level=1, out_data=5 one cycle after the first capture.
REQ-034 count_in sequence 1,2,2,3 with capture_en=1, out_ready=1 -> out_data sequence 1,2,3, each valid for one cycle.
REQ-035 Six distinct values 0..5 captured with out_ready=0, DEPTH=4 -> level=4, overflow=1 after the 5th value; popping yields 0,1,2,3.
REQ-036 Full FIFO, distinct push with out_ready=1 in the same cycle -> level stays 4, overflow stays 0, new value exits last.
REQ-037 overflow=1, clr_ovf=1 coinciding with a dropped push -> overflow=1; clr_ovf=1 alone on the next cycle -> overflow=0.
REQ-038 rst pulsed low mid-stream with level=3 -> outputs clear asynchronously; next capture of the previously seen value is pushed.
